line_memory_responder: RTL and testbench

- Responder end of the 256-bit cache-line memory interface.
- The data-cache controller acts as initiator: it raises enable with address, write flag and line data, then holds the request until ack.
- This block accepts one line request at a time, waits a fixed latency, performs the line read or write on its internal array, and returns a single-cycle ack with read data.
- It sits at top level beside the CPU and connects directly to the CPU's memory-side ports.

---
 rtl/line_memory_responder.sv | 71 +++++++
 tb/tb_line_memory_responder.sv | 131 +++++++++++++
 2 files changed

// File: rtl/line_memory_responder.sv
// line_memory_responder: 256-bit cache-line memory responder with fixed access latency
// Ports: clk_i clock; rst_i synchronous active-high reset; addr_i byte address of line;
//        data_i write line; enable_i request, held until ack; write_i 1=write 0=read;
//        ack_o registered one-cycle completion pulse; data_o registered last read line.
module line_memory_responder #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic wr_q, wr_d, ack_q, ack_d, accept;
  logic [LINE_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [LINE_W-1:0] mem [DEPTH];
  logic unused_addr;
  assign unused_addr = ^{addr_i[ADDR_W-1:IW+5], addr_i[4:0]};
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  // ACK is the final latency cycle; the access and the registered ack land on the edge leaving it,
  // so the responder is back in IDLE while ack_o is visible.
  always_ff @(posedge clk_i)
    if (!rst_i && state_q == ACK && wr_q) mem[idx_q] <= wdata_q;
  always_comb begin
    state_d = state_q == IDLE ? (enable_i ? (LATENCY == 1 ? ACK : WAIT) : IDLE)
            : state_q == WAIT ? (cnt_q == CW'(1) ? ACK : WAIT)
            : IDLE;
  end
  always_comb begin
    accept  = state_q == IDLE && enable_i;
    cnt_d   = accept ? CW'(LATENCY - 1) : state_q == WAIT ? cnt_q - CW'(1) : cnt_q;
    idx_d   = accept ? addr_i[IW+4:5] : idx_q;
    wr_d    = accept ? write_i : wr_q;
    wdata_d = accept ? data_i : wdata_q;
    ack_d   = state_q == ACK;
    rdata_d = state_q == ACK && !wr_q ? mem[idx_q] : rdata_q;
  end
  always_comb begin
    ack_o  = ack_q;
    data_o = rdata_q;
  end
endmodule

// File: tb/tb_line_memory_responder.sv
module tb_line_memory_responder;
  logic clk = 1'b0, rst_i = 1'b1, enable_i = 1'b0, write_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [255:0] data_i = '0;
  logic ack_o;
  logic [255:0] data_o;
  localparam logic [255:0] DB = {8{32'hDEADBEEF}};
  localparam logic [255:0] P2 = {8{32'hCAFEF00D}};
  localparam logic [255:0] Q3 = {8{32'h0BADC0DE}};
  localparam logic [255:0] W3 = {8{32'h12345678}};
  localparam logic [255:0] C5 = {8{32'h55AA55AA}};
  localparam logic [255:0] LA = {8{32'hA5A5A5A5}};
  localparam logic [255:0] LB = {8{32'h5A5A5A5A}};
  line_memory_responder dut (
    .clk_i(clk), .rst_i(rst_i), .addr_i(addr_i), .data_i(data_i),
    .enable_i(enable_i), .write_i(write_i), .ack_o(ack_o), .data_o(data_o)
  );
  always #5 clk = ~clk;
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;
  typedef struct { logic [255:0] d; int e; } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  logic [255:0] last_rd = '0;
  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask
  always @(negedge clk)
    if (ack_o === 1'b1) begin
      exp_t x;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected ack at edge %0d: got ack with no request pending", edge_n);
      end else begin
        x = sb.pop_front();
        check("ack edge", 256'(edge_n), 256'(x.e));
        check("ack data", data_o, x.d);
      end
    end
  task automatic wait_ack();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack_o === 1'b1) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL ack timeout at edge %0d: got no ack within 40 cycles", edge_n);
  endtask
  task automatic req(input logic wr, input logic [31:0] a, input logic [255:0] d, input logic [255:0] ex);
    @(negedge clk);
    enable_i = 1'b1;
    write_i = wr;
    addr_i = a;
    data_i = d;
    sb.push_back(exp_t'{ex, edge_n + 11});
    wait_ack();
    enable_i = 1'b0;
  endtask
  initial begin
    enable_i = 1'b1;
    write_i = 1'b1;
    addr_i = 32'h40;
    data_i = P2;
    repeat (2) begin
      @(negedge clk);
      check("reset ack", 256'(ack_o), 256'(0));
      check("reset data", data_o, 256'(0));
    end
    rst_i = 1'b0;
    sb.push_back(exp_t'{256'(0), edge_n + 11});
    wait_ack();
    enable_i = 1'b0;
    req(1'b1, 32'h20, DB, 256'(0));
    req(1'b0, 32'h20, '0, DB);
    req(1'b0, 32'h3F, '0, DB);
    req(1'b0, 32'h4020, '0, DB);
    req(1'b0, 32'h40, '0, P2);
    last_rd = P2;
    @(negedge clk);
    enable_i = 1'b1;
    write_i = 1'b0;
    addr_i = 32'h20;
    sb.push_back(exp_t'{DB, edge_n + 11});
    sb.push_back(exp_t'{P2, edge_n + 22});
    wait_ack();
    addr_i = 32'h40;
    wait_ack();
    enable_i = 1'b0;
    last_rd = P2;
    req(1'b1, 32'h60, Q3, last_rd);
    @(negedge clk);
    enable_i = 1'b1;
    write_i = 1'b1;
    addr_i = 32'h60;
    data_i = W3;
    repeat (5) @(negedge clk);
    rst_i = 1'b1;
    enable_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    check("post-reset data", data_o, 256'(0));
    last_rd = '0;
    repeat (15) @(negedge clk);
    req(1'b0, 32'h60, '0, Q3);
    last_rd = Q3;
    req(1'b1, 32'hA0, C5, last_rd);
    @(negedge clk);
    enable_i = 1'b1;
    write_i = 1'b1;
    addr_i = 32'h80;
    data_i = LA;
    sb.push_back(exp_t'{last_rd, edge_n + 11});
    repeat (3) @(negedge clk);
    addr_i = 32'hA0;
    data_i = LB;
    write_i = 1'b0;
    wait_ack();
    enable_i = 1'b0;
    req(1'b0, 32'h80, '0, LA);
    req(1'b0, 32'hA0, '0, C5);
    repeat (5) @(negedge clk);
    check("scoreboard empty", 256'(sb.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
